// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, registered instruction,
// valid/ready handoff to decode, PC steering from PCSrc/ImmExt.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  output logic [XLEN-1:0] Instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            misalign
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;

  assign target  = pc + ImmExt;
  assign PCPlus4 = pc + XLEN'(4);
  // Branch targets are word-aligned by dropping the low bits; misalign flags it.
  assign next_pc = PCSrc ? {target[XLEN-1:2], 2'b00} : PCPlus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      instr    <= XLEN'(32'h0000_0013);
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        S_REQ:  if (imem_ready) state <= S_WAIT;
        S_WAIT: if (imem_rvalid) begin
          instr <= imem_rdata;
          state <= S_HOLD;
        end
        S_HOLD: if (instr_ready) begin
          pc       <= next_pc;
          state    <= S_REQ;
          misalign <= PCSrc && (target[1:0] != 2'b00);
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign Instr       = instr;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[30];
  assign PC          = pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the `op`/`funct3`/`funct7` fields consumed by `control` and steers the PC using `control`'s `PCSrc` decision. It holds the PC, issues one request at a time to instruction memory, registers the returned word, and presents it downstream with a valid/ready handshake. It sits between the instruction-memory port and the decode/`control` block of the riscy32 core.

## Interface
Parameters:
- `XLEN`, 32, PC and instruction width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `imem_req`  out  1  Request valid to instruction memory.
- `imem_addr`  out  XLEN  Fetch address; equals `PC` while `imem_req` is high.
- `imem_ready`  in  1  Memory accepts the request this cycle.
- `imem_rvalid`  in  1  Read data valid.
- `imem_rdata`  in  XLEN  Instruction word.
- `instr_valid`  out  1  `Instr` and the decoded fields are valid.
- `instr_ready`  in  1  Downstream has executed the instruction. `PCSrc`/`ImmExt` are sampled in this cycle.
- `PCSrc`  in  1  Take the branch or jump target.
- `ImmExt`  in  XLEN  Sign-extended offset. Target is `PC + ImmExt`.
- `Instr`  out  XLEN  Registered instruction word.
- `op`  out  7  `Instr[6:0]`.
- `funct3`  out  3  `Instr[14:12]`.
- `funct7`  out  1  `Instr[30]`.
- `PC`  out  XLEN  Address of `Instr`.
- `PCPlus4`  out  XLEN  `PC + 4`, modulo 2^XLEN.
- `misalign`  out  1  One-cycle pulse: the taken target had nonzero bits [1:0].

## Operation
- FSM states:
  - **REQ**: `imem_req` = 1, `imem_addr` = `PC`. On `imem_ready` go to WAIT.
  - **WAIT**: `imem_req` = 0. On `imem_rvalid`, capture `imem_rdata` into `Instr` and go to HOLD.
  - **HOLD**: `instr_valid` = 1. On `instr_ready`, load the next PC and go to REQ.
- Next PC:
  - `PCSrc` = 1: `(PC + ImmExt)` with bits [1:0] forced to 00. `misalign` pulses in the cycle after the handshake if the raw target had bits [1:0] ≠ 0.
  - `PCSrc` = 0: `PC + 4`.
- Arithmetic is XLEN-bit, with no carry out. `32'hFFFF_FFFC + 4` wraps to `0`. A negative `ImmExt` wraps the same way.
- Only one request is outstanding at a time.
  - `imem_rvalid` outside WAIT is ignored.
  - `imem_rvalid` in the same cycle as the REQ acceptance is ignored. Data is required no earlier than the cycle after acceptance.
- `Instr`, `op`, `funct3` and `funct7` stay stable for the whole of HOLD. They change only on capture in WAIT.
- `PCSrc` and `ImmExt` are ignored outside the HOLD handshake cycle.

## Timing
- Reset (async assert, sync release). Values on reset:
  - state = REQ
  - `PC` = `RESET_PC`
  - `Instr` = 32'h0000_0013 (nop), so `op` = 7'b0010011, `funct3` = 0, `funct7` = 0
  - `instr_valid` = 0, `misalign` = 0
  - `imem_req` = 1 in the first cycle after release
- Reset asserted mid-operation: the state returns to REQ immediately. Any outstanding memory response is dropped. `instr_valid` drops immediately.
- Zero-wait memory (`imem_ready` = 1, `imem_rvalid` one cycle later):
  - REQ at cycle t, WAIT at t+1, `instr_valid` at t+2.
  - Handshake at t+2 gives the next REQ at t+3 with the updated PC.
  - Minimum 3 cycles per instruction.
- Holding `imem_ready` low stalls REQ indefinitely with `imem_addr` stable.
- Holding `instr_ready` low holds HOLD indefinitely.
- `misalign` is registered and high for exactly one cycle, coincident with the first REQ cycle at the new PC.

## Test plan
- **Reset/first fetch**:
  - Stimulus: release `rst_n`, `imem_ready` = 1, `imem_rvalid` one cycle later with data 32'h0020_81B3 (add).
  - Required: `imem_addr` = 0 at t. `instr_valid` at t+2 with `op` = 7'b0110011, `funct3` = 0, `funct7` = 0, `PC` = 0, `PCPlus4` = 4.
- **Sequential**:
  - Stimulus: `PCSrc` = 0 on three consecutive handshakes.
  - Required: fetch addresses 0, 4, 8, 12. Three cycles per instruction.
- **Taken branch**:
  - Stimulus: at `PC` = 0x10, `PCSrc` = 1, `ImmExt` = 32'hFFFF_FFF8.
  - Required: next `imem_addr` = 0x08, `misalign` = 0.
  - Stimulus: `ImmExt` = 6 from `PC` = 0x08.
  - Required: next `imem_addr` = 0x0C, `misalign` pulses for 1 cycle.
- **Stalls**:
  - Stimulus: `imem_ready` low for 4 cycles, then `imem_rvalid` 3 cycles late, then `instr_ready` low for 5 cycles.
  - Required: `imem_addr` stable during the stall, a single capture, `Instr` and `op` stable throughout HOLD, `imem_req` = 0 during WAIT and HOLD.
- **Wrap and spurious data**:
  - Stimulus: `RESET_PC` = 32'hFFFF_FFFC, `PCSrc` = 0.
  - Required: next address 0.
  - Stimulus: pulse `imem_rvalid` in REQ and in HOLD.
  - Required: `Instr` unchanged.
- **Reset mid-WAIT**:
  - Stimulus: assert `rst_n` low during WAIT, then release.
  - Required: `instr_valid` = 0 immediately, `Instr` = nop, refetch from `RESET_PC`. A late `imem_rvalid` arriving in REQ is ignored.
